// File: rtl/ssd_scan_decoder.sv
// Receive-side monitor for the multiplexed seven-segment display.
// Synchronises the anode/cathode pins, waits for each digit slot to settle,
// then decodes the cathode pattern back to a hex value for that digit.
module ssd_scan_decoder #(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic [3:0]  an_n,
  input  logic [6:0]  ca_n,
  input  logic        dp_n,
  output logic [15:0] digit_bus,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic [3:0]  pattern_err,
  output logic [3:0]  dp_seen,
  output logic        frame_done,
  output logic        multi_anode_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETTLING = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;

  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  // Pins reset to the "display dark" level so no slot is seen coming out of reset
  localparam logic [11:0] PINS_IDLE = 12'hFFF;

  logic [11:0]      sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] settleCnt_q, settleCnt_d;
  logic [1:0]       state_q, state_d;
  logic [15:0]      digitBus_q, digitBus_d;
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       blank_q, blank_d;
  logic [3:0]       patErr_q, patErr_d;
  logic [3:0]       dpSeen_q, dpSeen_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0]       seenNext;
  logic             frameDone_q, frameDone_d;
  logic             multiErr_q, multiErr_d;

  logic [3:0] sampleAn;
  logic [6:0] sampleCa;
  logic       sampleDp;
  logic [3:0] anLow;
  logic       anIdle;
  logic       stable;
  logic       oneHot;
  logic       doCapture;
  logic       doMulti;
  logic [4:0] glyph;

  assign sampleAn = sync2_q[11:8];
  assign sampleCa = sync2_q[7:1];
  assign sampleDp = sync2_q[0];
  assign anLow    = ~sampleAn;
  assign anIdle   = (sampleAn == 4'b1111);
  assign stable   = (sync2_q == prev_q);
  assign oneHot   = (anLow != 4'd0) && ((anLow & (anLow - 4'd1)) == 4'd0);
  assign glyph    = decodeGlyph(sampleCa);

  // Returns {legal, value}; legal is 0 for blank and for unknown patterns
  function automatic logic [4:0] decodeGlyph(input logic [6:0] ca);
    logic [4:0] r;
    case (ca)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = 5'd0;
    endcase
    return r;
  endfunction

  // Two-flop synchroniser on all pins, plus one more stage to detect changes
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync1_q <= PINS_IDLE;
      sync2_q <= PINS_IDLE;
      prev_q  <= PINS_IDLE;
    end else begin
      sync1_q <= {an_n, ca_n, dp_n};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Settle counter restarts on any pin change and saturates at the settle time
  always_comb begin
    settleCnt_d = settleCnt_q;
    if (!stable)
      settleCnt_d = '0;
    else if (settleCnt_q != SETTLE_MAX)
      settleCnt_d = settleCnt_q + CNT_W'(1);
  end

  // Slot tracking: capture once per settled slot, then hold until the pins move
  always_comb begin
    state_d   = state_q;
    doCapture = 1'b0;
    doMulti   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!anIdle) state_d = SETTLING;
      end
      SETTLING: begin
        if (anIdle) begin
          state_d = IDLE;
        end else if (stable && settleCnt_q == SETTLE_MAX) begin
          state_d   = HELD;
          doCapture = oneHot;
          doMulti   = !oneHot;
        end
      end
      HELD: begin
        if (!stable) state_d = anIdle ? IDLE : SETTLING;
      end
      default: state_d = IDLE;
    endcase
  end

  // Update the captured digit's outputs and the frame seen-mask
  always_comb begin
    digitBus_d  = digitBus_q;
    valid_d     = valid_q;
    blank_d     = blank_q;
    patErr_d    = patErr_q;
    dpSeen_d    = dpSeen_q;
    seen_d      = seen_q;
    seenNext    = seen_q | anLow;
    frameDone_d = 1'b0;
    multiErr_d  = doMulti;
    if (doCapture) begin
      for (int i = 0; i < 4; i++) begin
        if (anLow[i]) begin
          valid_d[i]  = 1'b1;
          dpSeen_d[i] = ~sampleDp;
          if (glyph[4]) begin
            digitBus_d[4*i +: 4] = glyph[3:0];
            blank_d[i]           = 1'b0;
            patErr_d[i]          = 1'b0;
          end else if (sampleCa == 7'b1111111) begin
            blank_d[i]  = 1'b1;
            patErr_d[i] = 1'b0;
          end else begin
            blank_d[i]  = 1'b0;
            patErr_d[i] = 1'b1;
          end
        end
      end
      if (seenNext == 4'b1111) begin
        frameDone_d = 1'b1;
        seen_d      = 4'd0;
      end else begin
        seen_d = seenNext;
      end
    end
  end

  // State, counter and output registers
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      settleCnt_q <= '0;
      digitBus_q  <= 16'd0;
      valid_q     <= 4'd0;
      blank_q     <= 4'd0;
      patErr_q    <= 4'd0;
      dpSeen_q    <= 4'd0;
      seen_q      <= 4'd0;
      frameDone_q <= 1'b0;
      multiErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      digitBus_q  <= digitBus_d;
      valid_q     <= valid_d;
      blank_q     <= blank_d;
      patErr_q    <= patErr_d;
      dpSeen_q    <= dpSeen_d;
      seen_q      <= seen_d;
      frameDone_q <= frameDone_d;
      multiErr_q  <= multiErr_d;
    end
  end

  assign digit_bus       = digitBus_q;
  assign digit_valid     = valid_q;
  assign blank           = blank_q;
  assign pattern_err     = patErr_q;
  assign dp_seen         = dpSeen_q;
  assign frame_done      = frameDone_q;
  assign multi_anode_err = multiErr_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder with a short settle time.
module tb_ssd_scan_decoder;

  localparam int SETTLE = 4;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0000100;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b1100000;
  localparam logic [6:0] GC = 7'b0110001;
  localparam logic [6:0] GD = 7'b1000010;
  localparam logic [6:0] GE = 7'b0110000;
  localparam logic [6:0] GF = 7'b0111000;
  localparam logic [6:0] GBLANK = 7'b1111111;
  localparam logic [6:0] GBAD   = 7'b1010101;

  logic        board_clk = 1'b0;
  logic        reset;
  logic [3:0]  an_n;
  logic [6:0]  ca_n;
  logic        dp_n;
  logic [15:0] digit_bus;
  logic [3:0]  digit_valid;
  logic [3:0]  blank;
  logic [3:0]  pattern_err;
  logic [3:0]  dp_seen;
  logic        frame_done;
  logic        multi_anode_err;

  int checkCount = 0;
  int failCount  = 0;
  int frameCnt   = 0;
  int multiCnt   = 0;
  int frameBase;
  int multiBase;

  ssd_scan_decoder #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .board_clk       (board_clk),
    .reset           (reset),
    .an_n            (an_n),
    .ca_n            (ca_n),
    .dp_n            (dp_n),
    .digit_bus       (digit_bus),
    .digit_valid     (digit_valid),
    .blank           (blank),
    .pattern_err     (pattern_err),
    .dp_seen         (dp_seen),
    .frame_done      (frame_done),
    .multi_anode_err (multi_anode_err)
  );

  // 100 MHz board clock
  always #5 board_clk = ~board_clk;

  // Count one-cycle pulses, sampled away from the active edge
  always @(negedge board_clk) begin
    if (frame_done === 1'b1) frameCnt++;
    if (multi_anode_err === 1'b1) multiCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Hold the given pin values for exactly 'cycles' clock periods
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] ca, input logic dp, input int cycles);
    @(negedge board_clk);
    an_n = an;
    ca_n = ca;
    dp_n = dp;
    repeat (cycles - 1) @(negedge board_clk);
  endtask

  task automatic scanDigit(input int idx, input logic [6:0] ca, input logic dp, input int cycles);
    logic [3:0] an;
    an = ~(4'b0001 << idx);
    applyStimulus(an, ca, dp, cycles);
  endtask

  task automatic idleSlot(input int cycles);
    applyStimulus(4'b1111, GBLANK, 1'b1, cycles);
  endtask

  initial begin
    reset = 1'b1;
    an_n  = 4'b1111;
    ca_n  = GBLANK;
    dp_n  = 1'b1;
    repeat (3) @(negedge board_clk);
    checkOutput("rst_bus", digit_bus, 16'h0000);
    checkOutput("rst_valid", digit_valid, 4'h0);
    checkOutput("rst_blank", blank, 4'h0);
    checkOutput("rst_perr", pattern_err, 4'h0);
    checkOutput("rst_dp", dp_seen, 4'h0);
    checkOutput("rst_frame", frame_done, 1'b0);
    checkOutput("rst_multi", multi_anode_err, 1'b0);
    reset = 1'b0;
    idleSlot(5);
    checkOutput("idle_valid", digit_valid, 4'h0);

    // First full scan "A","2","1","0" with the dot on digit 1
    frameBase = frameCnt;
    scanDigit(0, GA, 1'b1, 20);
    scanDigit(1, G2, 1'b0, 20);
    scanDigit(2, G1, 1'b1, 20);
    checkOutput("frame1_not_early", frameCnt, frameBase);
    checkOutput("frame1_valid_partial", digit_valid, 4'b0111);
    scanDigit(3, G0, 1'b1, 20);
    checkOutput("frame1_bus", digit_bus, 16'h012A);
    checkOutput("frame1_valid", digit_valid, 4'hF);
    checkOutput("frame1_pulses", frameCnt, frameBase + 1);
    checkOutput("frame1_dp", dp_seen, 4'b0010);
    checkOutput("frame1_blank", blank, 4'h0);
    checkOutput("frame1_perr", pattern_err, 4'h0);

    // Second scan "4","6","9","8" with dots on digits 0 and 3
    scanDigit(0, G4, 1'b0, 20);
    scanDigit(1, G6, 1'b1, 20);
    scanDigit(2, G9, 1'b1, 20);
    scanDigit(3, G8, 1'b0, 20);
    checkOutput("frame2_bus", digit_bus, 16'h8964);
    checkOutput("frame2_pulses", frameCnt, frameBase + 2);
    checkOutput("frame2_dp", dp_seen, 4'b1001);

    // Blank glyph on digit 2 keeps the previous "5"
    scanDigit(2, G5, 1'b1, 20);
    checkOutput("digit2_five", digit_bus, 16'h8564);
    scanDigit(2, GBLANK, 1'b1, 20);
    checkOutput("blank_bus", digit_bus, 16'h8564);
    checkOutput("blank_flag", blank, 4'b0100);
    checkOutput("blank_perr", pattern_err, 4'h0);

    // Illegal glyph on digit 1, then a legal "7" clears the error
    scanDigit(1, GBAD, 1'b1, 20);
    checkOutput("bad_perr", pattern_err, 4'b0010);
    checkOutput("bad_bus", digit_bus, 16'h8564);
    checkOutput("bad_blank", blank, 4'b0100);
    scanDigit(1, G7, 1'b1, 20);
    checkOutput("seven_perr", pattern_err, 4'h0);
    checkOutput("seven_bus", digit_bus, 16'h8574);

    // Two anodes low at once
    frameBase = frameCnt;
    multiBase = multiCnt;
    idleSlot(10);
    applyStimulus(4'b1100, G8, 1'b0, 10);
    idleSlot(10);
    checkOutput("multi_pulses", multiCnt, multiBase + 1);
    checkOutput("multi_bus", digit_bus, 16'h8574);
    checkOutput("multi_dp", dp_seen, 4'b1001);
    checkOutput("multi_blank", blank, 4'b0100);
    checkOutput("multi_frame", frameCnt, frameBase);

    // Short slots on digit 0: 3 and 5 cycles are glitches, 6 cycles captures
    scanDigit(0, GC, 1'b1, 3);
    idleSlot(10);
    checkOutput("glitch3_bus", digit_bus, 16'h8574);
    scanDigit(0, GC, 1'b1, SETTLE + 1);
    idleSlot(10);
    checkOutput("glitch5_bus", digit_bus, 16'h8574);
    checkOutput("glitch5_dp", dp_seen, 4'b1001);
    scanDigit(0, GC, 1'b1, SETTLE + 2);
    idleSlot(10);
    checkOutput("slot6_bus", digit_bus, 16'h857C);
    checkOutput("slot6_dp", dp_seen, 4'b1000);
    checkOutput("slot6_frame", frameCnt, frameBase);

    // Digits 0..2 captured, then reset while digit 3 is still settling
    scanDigit(0, G1, 1'b0, 20);
    scanDigit(1, GBAD, 1'b1, 20);
    scanDigit(2, GBLANK, 1'b1, 20);
    checkOutput("prerst_bus", digit_bus, 16'h8571);
    checkOutput("prerst_perr", pattern_err, 4'b0010);
    checkOutput("prerst_blank", blank, 4'b0100);
    checkOutput("prerst_frame", frameCnt, frameBase);
    scanDigit(3, GD, 1'b1, 5);
    reset = 1'b1;
    an_n  = 4'b1111;
    ca_n  = GBLANK;
    dp_n  = 1'b1;
    #1;
    checkOutput("midrst_bus", digit_bus, 16'h0000);
    checkOutput("midrst_valid", digit_valid, 4'h0);
    checkOutput("midrst_blank", blank, 4'h0);
    checkOutput("midrst_perr", pattern_err, 4'h0);
    checkOutput("midrst_dp", dp_seen, 4'h0);
    repeat (3) @(negedge board_clk);
    reset = 1'b0;
    idleSlot(5);
    checkOutput("postrst_valid", digit_valid, 4'h0);
    checkOutput("postrst_frame", frameCnt, frameBase);

    // Fresh frame in order 3,0,1,2 completes only on the last digit
    scanDigit(3, GD, 1'b1, 20);
    scanDigit(0, GE, 1'b1, 20);
    scanDigit(1, GF, 1'b1, 20);
    checkOutput("frame3_not_early", frameCnt, frameBase);
    scanDigit(2, GB, 1'b0, 20);
    checkOutput("frame3_pulses", frameCnt, frameBase + 1);
    checkOutput("frame3_bus", digit_bus, 16'hDBFE);
    checkOutput("frame3_valid", digit_valid, 4'hF);
    checkOutput("frame3_dp", dp_seen, 4'b0100);
    checkOutput("frame3_perr", pattern_err, 4'h0);
    idleSlot(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
